// File: rtl/issue_queue_pkg.sv
// Shared types for the issue queue: instruction format, functional unit and
// the stored entry layout.
package issue_queue_pkg;

    // Entry payload is stored at this width; narrower instances use the low bits.
    localparam int IQ_MAX_PAYLOAD_WIDTH = 64;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } e_instruction_format;

    typedef enum logic [2:0] {
        FU_ALU,
        FU_MUL,
        FU_DIV,
        FU_LSU,
        FU_BRU,
        FU_CSR
    } e_functional_unit;

    typedef struct packed {
        logic [4:0]                      rd;
        logic [4:0]                      rs1;
        logic [4:0]                      rs2;
        e_instruction_format             insn_fmt;
        e_functional_unit                station;
        logic [IQ_MAX_PAYLOAD_WIDTH-1:0] payload;
    } s_issue_entry;

endpackage

// File: rtl/issue_queue_if.sv
// Enqueue / head-presentation / issue bundle between the dispatch side
// (master) and the issue queue (slave).
interface issue_queue_if #(
    parameter int DEPTH         = 8,
    parameter int MULTI_ISSUE   = 3,
    parameter int PAYLOAD_WIDTH = 64
);
    import issue_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = $clog2(MULTI_ISSUE) + 1;

    logic                                         flush_i;
    logic [LW-1:0]                                enq_cnt_i;
    logic [MULTI_ISSUE-1:0][4:0]                  enq_rd_i;
    logic [MULTI_ISSUE-1:0][4:0]                  enq_rs1_i;
    logic [MULTI_ISSUE-1:0][4:0]                  enq_rs2_i;
    e_instruction_format [MULTI_ISSUE-1:0]        enq_insn_fmt_i;
    e_functional_unit [MULTI_ISSUE-1:0]           enq_station_i;
    logic [MULTI_ISSUE-1:0][PAYLOAD_WIDTH-1:0]    enq_payload_i;
    logic [LW-1:0]                                issue_cnt_i;

    logic [CW-1:0]                                free_cnt_o;
    logic                                         overflow_o;
    logic [LW-1:0]                                queue_rdy_cnt_o;
    logic [MULTI_ISSUE-1:0][4:0]                  queue_rd_o;
    logic [MULTI_ISSUE-1:0][4:0]                  queue_rs1_o;
    logic [MULTI_ISSUE-1:0][4:0]                  queue_rs2_o;
    e_instruction_format [MULTI_ISSUE-1:0]        queue_insn_fmt_o;
    e_functional_unit [MULTI_ISSUE-1:0]           queue_stations_o;
    logic [MULTI_ISSUE-1:0][PAYLOAD_WIDTH-1:0]    queue_payload_o;

    modport master (
        output flush_i, enq_cnt_i, enq_rd_i, enq_rs1_i, enq_rs2_i,
               enq_insn_fmt_i, enq_station_i, enq_payload_i, issue_cnt_i,
        input  free_cnt_o, overflow_o, queue_rdy_cnt_o, queue_rd_o,
               queue_rs1_o, queue_rs2_o, queue_insn_fmt_o,
               queue_stations_o, queue_payload_o
    );

    modport slave (
        input  flush_i, enq_cnt_i, enq_rd_i, enq_rs1_i, enq_rs2_i,
               enq_insn_fmt_i, enq_station_i, enq_payload_i, issue_cnt_i,
        output free_cnt_o, overflow_o, queue_rdy_cnt_o, queue_rd_o,
               queue_rs1_o, queue_rs2_o, queue_insn_fmt_o,
               queue_stations_o, queue_payload_o
    );

endinterface

// File: rtl/issue_queue.sv
// In-order multi-issue queue: circular buffer accepting up to MULTI_ISSUE
// entries per cycle and presenting the oldest MULTI_ISSUE at its head.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int MULTI_ISSUE   = 3,
    parameter int PAYLOAD_WIDTH = 64
) (
    input logic          clk,
    input logic          rst,
    issue_queue_if.slave iq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(MULTI_ISSUE) + 1;

    s_issue_entry    mem [DEPTH];
    s_issue_entry    lane_entry [MULTI_ISSUE];
    logic [PW-1:0]   slot_idx [MULTI_ISSUE];

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            overflow;

    logic [CW-1:0]   free_cnt;
    logic [CW-1:0]   accepted;
    logic [LW-1:0]   rdy_cnt;
    logic [LW-1:0]   pop_cnt;
    logic            enq_ok;

    assign free_cnt = CW'(DEPTH) - count;
    assign rdy_cnt  = (count >= CW'(MULTI_ISSUE)) ? LW'(MULTI_ISSUE) : LW'(count);
    assign pop_cnt  = (iq.issue_cnt_i > rdy_cnt) ? rdy_cnt : iq.issue_cnt_i;
    // Admission uses registered free space only, so a same-cycle pop never helps.
    assign enq_ok   = CW'(iq.enq_cnt_i) <= free_cnt;
    assign accepted = enq_ok ? CW'(iq.enq_cnt_i) : CW'(0);

    always_comb begin
        for (int l = 0; l < MULTI_ISSUE; l++) begin
            lane_entry[l]          = '0;
            lane_entry[l].rd       = iq.enq_rd_i[l];
            lane_entry[l].rs1      = iq.enq_rs1_i[l];
            lane_entry[l].rs2      = iq.enq_rs2_i[l];
            lane_entry[l].insn_fmt = iq.enq_insn_fmt_i[l];
            lane_entry[l].station  = iq.enq_station_i[l];
            lane_entry[l].payload[PAYLOAD_WIDTH-1:0] = iq.enq_payload_i[l];
        end
    end

    // Storage carries no reset; unoccupied slots are masked at the head.
    always_ff @(posedge clk) begin
        if (rst && !iq.flush_i && enq_ok) begin
            for (int l = 0; l < MULTI_ISSUE; l++) begin
                if (l < int'(iq.enq_cnt_i)) begin
                    mem[tail + PW'(l)] <= lane_entry[l];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (iq.flush_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= !enq_ok;
            if (enq_ok) begin
                tail <= tail + PW'(iq.enq_cnt_i);
            end
            head  <= head + PW'(pop_cnt);
            count <= count + accepted - CW'(pop_cnt);
        end
    end

    always_comb begin
        iq.queue_rd_o       = '0;
        iq.queue_rs1_o      = '0;
        iq.queue_rs2_o      = '0;
        iq.queue_insn_fmt_o = {MULTI_ISSUE{FMT_R}};
        iq.queue_stations_o = {MULTI_ISSUE{FU_ALU}};
        iq.queue_payload_o  = '0;
        for (int k = 0; k < MULTI_ISSUE; k++) begin
            slot_idx[k] = head + PW'(k);
            if (LW'(k) < rdy_cnt) begin
                iq.queue_rd_o[k]       = mem[slot_idx[k]].rd;
                iq.queue_rs1_o[k]      = mem[slot_idx[k]].rs1;
                iq.queue_rs2_o[k]      = mem[slot_idx[k]].rs2;
                iq.queue_insn_fmt_o[k] = mem[slot_idx[k]].insn_fmt;
                iq.queue_stations_o[k] = mem[slot_idx[k]].station;
                iq.queue_payload_o[k]  = mem[slot_idx[k]].payload[PAYLOAD_WIDTH-1:0];
            end
        end
    end

    assign iq.free_cnt_o      = free_cnt;
    assign iq.overflow_o      = overflow;
    assign iq.queue_rdy_cnt_o = rdy_cnt;

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; power of two, >= 2*MULTI_ISSUE.
REQ-002 Parameter MULTI_ISSUE, default 3, max entries enqueued, presented or popped per cycle.
REQ-003 Parameter PAYLOAD_WIDTH, default 64, opaque per-entry data (imm/pc), carried untouched.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 flush_i  in  1  discard all entries this cycle.
REQ-007 enq_cnt_i  in  $clog2(MULTI_ISSUE)+1  number of valid enqueue lanes, lanes 0..enq_cnt_i-1.
REQ-008 enq_rd_i/enq_rs1_i/enq_rs2_i  in  5 x MULTI_ISSUE  register indices per lane.
REQ-009 enq_insn_fmt_i  in  e_instruction_format x MULTI_ISSUE  format per lane.
REQ-010 enq_station_i  in  e_functional_unit x MULTI_ISSUE  target station per lane.
REQ-011 enq_payload_i  in  PAYLOAD_WIDTH x MULTI_ISSUE  payload per lane.
REQ-012 free_cnt_o  out  $clog2(DEPTH)+1  empty slots at start of cycle.
REQ-013 overflow_o  out  1  one-cycle pulse, enqueue rejected.
REQ-014 queue_rdy_cnt_o  out  $clog2(MULTI_ISSUE)+1  min(count, MULTI_ISSUE).
REQ-015 queue_rd_o/queue_rs1_o/queue_rs2_o/queue_insn_fmt_o/queue_stations_o/queue_payload_o  out  per-field x MULTI_ISSUE  head entries, slot 0 oldest.
REQ-016 issue_cnt_i  in  $clog2(MULTI_ISSUE)+1  entries consumed from head this cycle.

Function
REQ-017 Circular buffer with head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus count of $clog2(DEPTH)+1 bits.
REQ-018 Head slot k (k<MULTI_ISSUE) SHALL show entry at (head+k) mod DEPTH combinationally from stored state; slots k >= queue_rdy_cnt_o SHALL drive all-zero.
REQ-019 free_cnt_o = DEPTH - count, from registered state only (no dependence on same-cycle pop).
REQ-020 If enq_cnt_i <= free_cnt_o, lanes 0..enq_cnt_i-1 SHALL be written at tail, tail+1, ... in lane order and tail advances by enq_cnt_i.
REQ-021 If enq_cnt_i > free_cnt_o, no lane written, tail unchanged, overflow_o = 1 next cycle for one cycle.
REQ-022 Pop: head advances by issue_cnt_i; issue_cnt_i > queue_rdy_cnt_o is illegal; queue SHALL clamp pop to queue_rdy_cnt_o.
REQ-023 Simultaneous enqueue and pop in one cycle both apply; count_next = count + accepted_enq - pop.
REQ-024 Issued entries are exactly the prefix 0..issue_cnt_i-1; no out-of-order removal.
REQ-025 Full (count = DEPTH): free_cnt_o = 0, any enq_cnt_i > 0 overflows even if a pop occurs that cycle.
REQ-026 Empty: queue_rdy_cnt_o = 0; an enqueue becomes visible at head the following cycle (1-cycle enqueue-to-present latency, no bypass).
REQ-027 flush_i has priority: head = tail = count = 0 next cycle; same-cycle enqueue and pop ignored; overflow_o = 0.

Reset
REQ-028 On rst = 0 at a clock edge: head, tail, count = 0; overflow_o = 0; queue_rdy_cnt_o = 0; free_cnt_o = DEPTH; head slots all-zero.
REQ-029 Entry storage need not be reset; outputs SHALL not expose it (REQ-018 masking).
REQ-030 Reset mid-operation SHALL override flush, enqueue and pop in that cycle.

Structure
REQ-031 Entry struct s_issue_entry (rd, rs1, rs2, insn_fmt, station, payload) SHALL be added to the shared types package beside e_instruction_format and e_functional_unit.
REQ-032 Single flat module; no sub-module required; storage is a register array of s_issue_entry.

Verification
REQ-033 Reset, then enq_cnt_i=3 with rd=1,2,3 -> next cycle queue_rdy_cnt_o=3, queue_rd_o={1,2,3}, free_cnt_o=5.
REQ-034 Fill to 8 entries, then enq_cnt_i=1 with issue_cnt_i=2 -> overflow_o=1 next cycle, count=6, tail unchanged.
REQ-035 count=7 at head index 6, enq 3, pop 2 each cycle for 6 cycles -> FIFO order preserved across wrap, count rises by 1 per cycle until overflow.
REQ-036 count=2, issue_cnt_i=3 -> pop clamped to 2, queue_rdy_cnt_o=0, slots zeroed.
REQ-037 count=5, flush_i=1 with enq_cnt_i=2 and issue_cnt_i=1 -> next cycle count=0, free_cnt_o=8, queue_rdy_cnt_o=0.
REQ-038 rst=0 asserted with count=4 and enq_cnt_i=3 -> next cycle all outputs at REQ-028 values.
